// File: rtl/mem_access_unit.sv
// mem_access_unit
// ----------------------------------------------------------------------------
// CPU-side sequencer. It turns 8-bit and 16-bit requests into byte-wide
// strobed accesses on a 256-byte block RAM. The RAM is read-first and acts on
// the rising level of mem_clk. A 16-bit word is stored little-endian: the low
// byte is at addr and the high byte is at addr+1 (mod 256). Every request
// returns exactly one response.
//
// Parameters
//   WAIT_CYC  clk_qzt cycles spent in WAIT after each strobe (>= 1)
//   CNT_W     width of acc_count
//
// Ports
//   clk_qzt, rst                    clock (posedge) and async active-high reset
//   req_valid/req_ready             request handshake
//   req_write, req_word             1=write / 1=16-bit access
//   req_addr, req_wdata             byte address and write data
//   rsp_valid, rsp_rdata            one-cycle completion pulse and read data
//                                   (for a write, the previous contents)
//   mem_en, mem_clk, mem_we         RAM enable, strobe and write enable
//   mem_addr, mem_wdata, mem_rdata  RAM address and data
//   acc_count                       completed-access count
//
// Optional feature: define MEM_ACCESS_CNT_EN to enable the saturating access
// counter. When it is undefined, acc_count is tied to zero.
module mem_access_unit #(
    parameter int WAIT_CYC = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk_qzt,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_word,
    input  logic [7:0]       req_addr,
    input  logic [15:0]      req_wdata,
    output logic             rsp_valid,
    output logic [15:0]      rsp_rdata,
    output logic             mem_en,
    output logic             mem_clk,
    output logic             mem_we,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    output logic [CNT_W-1:0] acc_count
);

    generate
        if (WAIT_CYC < 1) begin : g_bad_wait_cyc
            $error("mem_access_unit: WAIT_CYC must be at least 1");
        end
    endgenerate

    localparam int WC_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [WC_W-1:0]   wait_cnt;
    logic              word_q;     // current request is a 16-bit access
    logic              byte_sel;   // 0 while handling the low byte, 1 for the high byte
    logic [7:0]        wdata_hi;   // high write byte, issued on the second strobe
    logic [15:0]       rdata_buf;  // bytes collected for the pending response

    always_ff @(posedge clk_qzt or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            word_q    <= 1'b0;
            byte_sel  <= 1'b0;
            wdata_hi  <= 8'h00;
            rdata_buf <= 16'h0000;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
            mem_en    <= 1'b0;
            mem_clk   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 8'h00;
            mem_wdata <= 8'h00;
        end else begin
            mem_en    <= 1'b1;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        word_q    <= req_word;
                        byte_sel  <= 1'b0;
                        wdata_hi  <= req_wdata[15:8];
                        rdata_buf <= 16'h0000;
                        mem_addr  <= req_addr;
                        mem_we    <= req_write;
                        mem_wdata <= req_wdata[7:0];
                        req_ready <= 1'b0;
                        state     <= S_PULSE;
                    end else begin
                        // mem_en is still low on the first edge after reset,
                        // so ready rises one edge later.
                        req_ready <= mem_en;
                    end
                end
                S_PULSE: begin
                    // Address, data and write enable were set one cycle earlier.
                    mem_clk  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    mem_clk <= 1'b0;
                    if (wait_cnt == WC_W'(WAIT_CYC - 1)) begin
                        if (byte_sel) begin
                            rdata_buf[15:8] <= mem_rdata;
                        end else begin
                            rdata_buf[7:0] <= mem_rdata;
                        end
                        if (word_q && !byte_sel) begin
                            byte_sel  <= 1'b1;
                            mem_addr  <= mem_addr + 8'd1;  // 0xFF wraps to 0x00
                            mem_wdata <= wdata_hi;
                            state     <= S_PULSE;
                        end else begin
                            mem_we <= 1'b0;
                            state  <= S_RESP;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rdata_buf;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ACCESS_CNT_EN
    // Saturating count of completed accesses; only reset clears it.
    always_ff @(posedge clk_qzt or posedge rst) begin
        if (rst) begin
            acc_count <= '0;
        end else if (state == S_RESP && acc_count != {CNT_W{1'b1}}) begin
            acc_count <= acc_count + CNT_W'(1);
        end
    end
`else
    assign acc_count = '0;
`endif

endmodule
